// File: rtl/udt_rx_parser.sv
// Receive-side UDT depacketiser: filters UDP datagrams by destination port/IP, strips the
// 16-byte UDT header, passes data payload through with decoded sideband and decodes control packets.
//
// state   | meaning
// IDLE    | wait for header beat 0 (W0/W1), apply port/IP/runt filter
// HDR1    | header beat 1 (W2/W3), branch on data/control
// PAYLOAD | zero-latency payload passthrough to rx_s_axis
// CIF     | first control-information beat
// CDRAIN  | discard remaining control beats
// DROP    | discard the rest of a rejected datagram
module udt_rx_parser #(
    parameter logic [15:0] PORT        = 16'd10086,
    parameter logic [31:0] FPGA_IP_SRC = 32'hc0a8006f,
    parameter bit          CHECK_IP    = 1'b1
) (
    input  logic        rx_s_axis_aclk,
    input  logic        rx_s_axis_aresetn,
    input  logic        udp_rx_tvalid,
    output logic        udp_rx_tready,
    input  logic        udp_rx_tlast,
    input  logic [7:0]  udp_rx_tkeep,
    input  logic [63:0] udp_rx_tdata,
    input  logic [31:0] udp_rx_ip_dest,
    input  logic [15:0] udp_rx_port_dest,
    output logic        rx_s_axis_tvalid,
    input  logic        rx_s_axis_tready,
    output logic        rx_s_axis_tlast,
    output logic [63:0] rx_s_axis_tdata,
    output logic [7:0]  rx_s_axis_tkeep,
    output logic [30:0] rx_seq_num,
    output logic [1:0]  rx_msg_pos,
    output logic        rx_in_order,
    output logic [28:0] rx_msg_num,
    output logic [31:0] rx_timestamp,
    output logic [31:0] rx_sock_id,
    output logic        ctrl_pkt_valid,
    output logic [14:0] ctrl_type,
    output logic [15:0] ctrl_ext_type,
    output logic [31:0] ctrl_add_info,
    output logic [31:0] ctrl_cif0,
    output logic [31:0] stat_data_cnt,
    output logic [31:0] stat_ctrl_cnt,
    output logic [31:0] stat_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_PAYLOAD, S_CIF, S_CDRAIN, S_DROP
    } state_t;

    function automatic logic [31:0] be32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] w0_q, w0_d, w1_q, w1_d, cif_q, cif_d;
    logic [30:0] seq_num_q, seq_num_d;
    logic [1:0]  msg_pos_q, msg_pos_d;
    logic        in_order_q, in_order_d;
    logic [28:0] msg_num_q, msg_num_d;
    logic [31:0] timestamp_q, timestamp_d;
    logic [31:0] sock_id_q, sock_id_d;
    logic        ctrl_valid_q, ctrl_valid_d;
    logic [14:0] ctrl_type_q, ctrl_type_d;
    logic [15:0] ctrl_ext_q, ctrl_ext_d;
    logic [31:0] ctrl_info_q, ctrl_info_d;
    logic [31:0] ctrl_cif0_q, ctrl_cif0_d;
    logic [31:0] data_cnt_q, data_cnt_d;
    logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    logic        in_payload;
    logic        beat;
    logic        keep_full;
    logic        hdr_ok;
    logic        emit;
    logic [31:0] emit_cif;

    assign in_payload = (state_q == S_PAYLOAD);
    assign udp_rx_tready = in_payload ? rx_s_axis_tready : 1'b1;
    assign beat = udp_rx_tvalid && udp_rx_tready;
    assign keep_full = (udp_rx_tkeep == 8'hFF);
    assign hdr_ok = keep_full && !udp_rx_tlast && (udp_rx_port_dest == PORT) &&
                    (!CHECK_IP || (udp_rx_ip_dest == FPGA_IP_SRC));

    // Payload is a pure wire path so the sink's backpressure reaches the UDP core the same cycle.
    assign rx_s_axis_tvalid = in_payload && udp_rx_tvalid;
    assign rx_s_axis_tlast  = in_payload && udp_rx_tlast;
    assign rx_s_axis_tdata  = in_payload ? udp_rx_tdata : 64'd0;
    assign rx_s_axis_tkeep  = in_payload ? udp_rx_tkeep : 8'd0;

    assign rx_seq_num     = seq_num_q;
    assign rx_msg_pos     = msg_pos_q;
    assign rx_in_order    = in_order_q;
    assign rx_msg_num     = msg_num_q;
    assign rx_timestamp   = timestamp_q;
    assign rx_sock_id     = sock_id_q;
    assign ctrl_pkt_valid = ctrl_valid_q;
    assign ctrl_type      = ctrl_type_q;
    assign ctrl_ext_type  = ctrl_ext_q;
    assign ctrl_add_info  = ctrl_info_q;
    assign ctrl_cif0      = ctrl_cif0_q;
    assign stat_data_cnt  = data_cnt_q;
    assign stat_ctrl_cnt  = ctrl_cnt_q;
    assign stat_drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d      = state_q;
        w0_d         = w0_q;
        w1_d         = w1_q;
        cif_d        = cif_q;
        seq_num_d    = seq_num_q;
        msg_pos_d    = msg_pos_q;
        in_order_d   = in_order_q;
        msg_num_d    = msg_num_q;
        timestamp_d  = timestamp_q;
        sock_id_d    = sock_id_q;
        ctrl_valid_d = 1'b0;
        ctrl_type_d  = ctrl_type_q;
        ctrl_ext_d   = ctrl_ext_q;
        ctrl_info_d  = ctrl_info_q;
        ctrl_cif0_d  = ctrl_cif0_q;
        data_cnt_d   = data_cnt_q;
        ctrl_cnt_d   = ctrl_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        emit         = 1'b0;
        emit_cif     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (hdr_ok) begin
                        w0_d    = be32(udp_rx_tdata[31:0]);
                        w1_d    = be32(udp_rx_tdata[63:32]);
                        state_d = S_HDR1;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = udp_rx_tlast ? S_IDLE : S_DROP;
                    end
                end
            end
            S_HDR1: begin
                if (beat) begin
                    if (!keep_full) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = udp_rx_tlast ? S_IDLE : S_DROP;
                    end else if (!w0_q[31]) begin
                        if (udp_rx_tlast) begin
                            drop_cnt_d = drop_cnt_q + 32'd1;
                            state_d    = S_IDLE;
                        end else begin
                            seq_num_d   = w0_q[30:0];
                            msg_pos_d   = w1_q[31:30];
                            in_order_d  = w1_q[29];
                            msg_num_d   = w1_q[28:0];
                            timestamp_d = be32(udp_rx_tdata[31:0]);
                            sock_id_d   = be32(udp_rx_tdata[63:32]);
                            state_d     = S_PAYLOAD;
                        end
                    end else if (udp_rx_tlast) begin
                        emit    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CIF;
                    end
                end
            end
            S_PAYLOAD: begin
                if (beat && udp_rx_tlast) begin
                    data_cnt_d = data_cnt_q + 32'd1;
                    state_d    = S_IDLE;
                end
            end
            S_CIF: begin
                if (beat) begin
                    cif_d = be32(udp_rx_tdata[31:0]);
                    if (udp_rx_tlast) begin
                        emit     = 1'b1;
                        emit_cif = be32(udp_rx_tdata[31:0]);
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_CDRAIN;
                    end
                end
            end
            S_CDRAIN: begin
                if (beat && udp_rx_tlast) begin
                    emit     = 1'b1;
                    emit_cif = cif_q;
                    state_d  = S_IDLE;
                end
            end
            S_DROP: begin
                if (beat && udp_rx_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Control fields are committed together with the pulse so they never change mid-event.
        if (emit) begin
            ctrl_valid_d = 1'b1;
            ctrl_type_d  = w0_q[30:16];
            ctrl_ext_d   = w0_q[15:0];
            ctrl_info_d  = w1_q;
            ctrl_cif0_d  = emit_cif;
            ctrl_cnt_d   = ctrl_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge rx_s_axis_aclk or negedge rx_s_axis_aresetn) begin
        if (!rx_s_axis_aresetn) begin
            state_q      <= S_IDLE;
            w0_q         <= 32'd0;
            w1_q         <= 32'd0;
            cif_q        <= 32'd0;
            seq_num_q    <= 31'd0;
            msg_pos_q    <= 2'd0;
            in_order_q   <= 1'b0;
            msg_num_q    <= 29'd0;
            timestamp_q  <= 32'd0;
            sock_id_q    <= 32'd0;
            ctrl_valid_q <= 1'b0;
            ctrl_type_q  <= 15'd0;
            ctrl_ext_q   <= 16'd0;
            ctrl_info_q  <= 32'd0;
            ctrl_cif0_q  <= 32'd0;
            data_cnt_q   <= 32'd0;
            ctrl_cnt_q   <= 32'd0;
            drop_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            w0_q         <= w0_d;
            w1_q         <= w1_d;
            cif_q        <= cif_d;
            seq_num_q    <= seq_num_d;
            msg_pos_q    <= msg_pos_d;
            in_order_q   <= in_order_d;
            msg_num_q    <= msg_num_d;
            timestamp_q  <= timestamp_d;
            sock_id_q    <= sock_id_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_type_q  <= ctrl_type_d;
            ctrl_ext_q   <= ctrl_ext_d;
            ctrl_info_q  <= ctrl_info_d;
            ctrl_cif0_q  <= ctrl_cif0_d;
            data_cnt_q   <= data_cnt_d;
            ctrl_cnt_q   <= ctrl_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule
